mcu_harvard_param: RTL
======================

// Module: mcu_harvard_param
// PURPOSE
//  Parametrised successor of the 3-cycle non-pipelined Harvard microcontroller.
//  Data width, program depth and data depth are generic; the program is streamed
//  in through a valid/ready loader after reset instead of coming from a fixed ROM.
//  Each instruction takes FETCH->DECODE->EXECUTE. Top-level core of the MCU subsystem.
// PARAMETERS
//  DW   8  data/Acc/DR width; operand field width; IW = 4+DW instruction width
//  AW   8  program address width (PROG_DEPTH = 2**AW); AW <= DW required
//  DAW  4  data-memory address width (DATA_DEPTH = 2**DAW); DAW <= DW required
// PORTS
//  clk        in   1      clock, all flops rising edge
//  rst        in   1      asynchronous, active-high reset
//  ld_valid   in   1      loader word valid
//  ld_ready   out  1      loader ready; 1 only in state LOAD
//  ld_data    in   IW     instruction word {opcode[3:0], operand[DW-1:0]}
//  ld_last    in   1      marks final program word (qualified by ld_valid&ld_ready)
//  state      out  3      LOAD=0 FETCH=1 DECODE=2 EXECUTE=3 HALT=4
//  pc         out  AW     program counter
//  acc        out  DW     accumulator
//  sr         out  4      flags {O,S,C,Z}
//  halted     out  1      1 while in HALT
// BEHAVIOUR
//  Reset: state=LOAD, pc=0, acc=0, sr=0, IR=0, DR=0, load_addr=0, halted=0. Memories
//   not reset; DMem contents undefined until written.
//  LOAD: on ld_valid&ld_ready write PMem[load_addr]<=ld_data, load_addr++. Leave to
//   FETCH (pc=0) the cycle after ld_last accepted or after word 2**AW-1 accepted.
//  FETCH: IR<=PMem[pc]. DECODE: DR<=DMem[IR[DAW-1:0]]. EXECUTE: commit Acc/SR/DMem/pc.
//   Exactly 3 cycles per instruction; pc=pc+1 mod 2**AW unless branch taken.
//  Opcodes (imm=IR[DW-1:0], m=DR):
//   0 NOP | 1 LDI acc=imm | 2 LD acc=m | 3 ST DMem[imm]=acc (WE only in EXECUTE)
//   4 ADD acc+=m | 5 SUB acc-=m | 6 AND | 7 OR | 8 XOR (acc op m) | 9 ADDI acc+=imm
//   A JMP pc=imm[AW-1:0] | B JZ if Z | C JC if C | D SHL acc<<1 | E SHR acc>>1 | F HALT
//  Flags: ADD/SUB/ADDI: Z, S=msb, C=carry out (SUB: C=1 on borrow, acc<m unsigned),
//   O=signed overflow. AND/OR/XOR: Z,S set; C,O cleared. SHL: C=old msb; SHR: C=old
//   lsb (logical); Z,S set, O cleared. LDI/LD: Z,S set; C,O kept. Others: SR unchanged.
//  Arithmetic mod 2**DW; DMem address = low DAW bits of imm (upper bits ignored).
//  HALT: state=HALT, halted=1, pc holds address of HALT; only rst exits.
//  ST then LD same address in next instruction returns new value (write in EXECUTE
//   precedes next DECODE read).
//  ld_valid outside LOAD ignored. rst mid-instruction or mid-load aborts at once; a
//   partial program is discarded (load restarts at address 0).
// CONFIGURATION
//  MCU_TRACE_EN defined: extra outputs trc_valid(1), trc_pc(AW), trc_ir(IW); trc_valid
//   pulses 1 cycle on each EXECUTE with pc/IR of the retiring instruction (also for
//   HALT). Reset 0. Not defined: ports absent, no trace logic; core behaviour identical.
// TESTING
//  Load {LDI 5, ADDI 3, HALT} -> acc=8, sr=0, halted=1 at cycle 9 after FETCH entry.
//  LDI 0xFF, ADDI 1 (DW=8) -> acc=0, Z=1, C=1, O=0; LDI 0x7F, ADDI 1 -> acc=0x80,S=1,O=1.
//  LDI 3, ST 2, LDI 0, LD 2 -> acc=3; SUB 2 with DMem[2]=3 -> acc=0, Z=1, C=0.
//  LDI 0, JZ 5 -> pc=5 after EXECUTE; LDI 1, JZ 5 -> pc increments; JMP at pc=255 wraps.
//  Loader: ld_valid toggling each cycle, ld_last on word 3 -> 3 words written, ld_ready
//   drops, FETCH next cycle; rst asserted mid-load -> state=LOAD, load restarts at 0.
//  MCU_TRACE_EN build: 3-instruction program -> exactly 3 trc_valid pulses, pc 0,1,2.

Source files
------------

// File: rtl/mcu_harvard_param.sv
// mcu_harvard_param: parametrised 3-cycle Harvard MCU core (FETCH/DECODE/EXECUTE).
// The program is streamed into PMem through a valid/ready loader after reset.
// Optional build macro MCU_TRACE_EN adds a retire trace port (trc_valid/trc_pc/trc_ir).
module mcu_harvard_param #(
  parameter int DW  = 8,
  parameter int AW  = 8,
  parameter int DAW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [DW+3:0]   ld_data,
  input  logic            ld_last,
  output logic [2:0]      state,
  output logic [AW-1:0]   pc,
  output logic [DW-1:0]   acc,
  output logic [3:0]      sr,
  output logic            halted
`ifdef MCU_TRACE_EN
  ,
  output logic            trc_valid,
  output logic [AW-1:0]   trc_pc,
  output logic [DW+3:0]   trc_ir
`endif
);

  localparam int IW = DW + 4;

  // Flag bit positions inside sr = {O,S,C,Z}
  localparam int F_Z = 0;
  localparam int F_C = 1;
  localparam int F_S = 2;
  localparam int F_O = 3;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_ST   = 4'h3;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t          cur, nxt;
  logic [AW-1:0]   load_addr;
  logic [IW-1:0]   ir;
  logic [DW-1:0]   dr;

  // Memories are not reset; DMem reads before a write return garbage.
  logic [IW-1:0]   pmem [2**AW];
  logic [DW-1:0]   dmem [2**DAW];

  logic [3:0]      op;
  logic [DW-1:0]   imm;
  logic [DAW-1:0]  dadr;
  logic            ld_acc, load_done;

  logic [DW-1:0]   acc_nxt, rhs;
  logic [3:0]      sr_nxt;
  logic [AW-1:0]   pc_nxt;
  logic [DW:0]     sum;
  logic            upd_zs;

  assign op     = ir[IW-1:DW];
  assign imm    = ir[DW-1:0];
  assign dadr   = ir[DAW-1:0];

  assign state    = cur;
  assign halted   = (cur == S_HALT);
  assign ld_ready = (cur == S_LOAD);
  assign ld_acc   = ld_ready && ld_valid;
  // Loading ends on an explicit last word or when the top PMem word is filled.
  assign load_done = ld_acc && (ld_last || (&load_addr));

`ifdef MCU_TRACE_EN
  // Retire trace: EXECUTE is the single retire cycle, IR/pc still belong to it.
  assign trc_valid = (cur == S_EXEC);
  assign trc_pc    = pc;
  assign trc_ir    = ir;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_LOAD;
    else     cur <= nxt;
  end

  // Next-state: loader, then a fixed 3-cycle ring until HALT retires
  always_comb begin
    nxt = cur;
    case (cur)
      S_LOAD:   if (load_done) nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = S_EXEC;
      S_EXEC:   nxt = (op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_LOAD;
    endcase
  end

  // Execute-stage ALU: results committed only in EXECUTE
  always_comb begin
    acc_nxt = acc;
    sr_nxt  = sr;
    pc_nxt  = pc + AW'(1);
    rhs     = '0;
    sum     = '0;
    upd_zs  = 1'b0;
    case (op)
      OP_LDI: begin acc_nxt = imm; upd_zs = 1'b1; end
      OP_LD:  begin acc_nxt = dr;  upd_zs = 1'b1; end
      OP_ADD, OP_ADDI: begin
        rhs            = (op == OP_ADD) ? dr : imm;
        sum            = {1'b0, acc} + {1'b0, rhs};
        acc_nxt        = sum[DW-1:0];
        upd_zs         = 1'b1;
        sr_nxt[F_C]    = sum[DW];
        sr_nxt[F_O]    = (acc[DW-1] == rhs[DW-1]) && (sum[DW-1] != acc[DW-1]);
      end
      OP_SUB: begin
        // Extended-width subtract: the top bit is the borrow (acc < m unsigned)
        sum            = {1'b0, acc} - {1'b0, dr};
        acc_nxt        = sum[DW-1:0];
        upd_zs         = 1'b1;
        sr_nxt[F_C]    = sum[DW];
        sr_nxt[F_O]    = (acc[DW-1] != dr[DW-1]) && (sum[DW-1] != acc[DW-1]);
      end
      OP_AND, OP_OR, OP_XOR: begin
        acc_nxt        = (op == OP_AND) ? (acc & dr) :
                         (op == OP_OR)  ? (acc | dr) : (acc ^ dr);
        upd_zs         = 1'b1;
        sr_nxt[F_C]    = 1'b0;
        sr_nxt[F_O]    = 1'b0;
      end
      OP_JMP: pc_nxt = imm[AW-1:0];
      OP_JZ:  if (sr[F_Z]) pc_nxt = imm[AW-1:0];
      OP_JC:  if (sr[F_C]) pc_nxt = imm[AW-1:0];
      OP_SHL: begin
        acc_nxt        = {acc[DW-2:0], 1'b0};
        upd_zs         = 1'b1;
        sr_nxt[F_C]    = acc[DW-1];
        sr_nxt[F_O]    = 1'b0;
      end
      OP_SHR: begin
        acc_nxt        = {1'b0, acc[DW-1:1]};
        upd_zs         = 1'b1;
        sr_nxt[F_C]    = acc[0];
        sr_nxt[F_O]    = 1'b0;
      end
      OP_HALT: pc_nxt = pc;
      default: ;
    endcase
    if (upd_zs) begin
      sr_nxt[F_Z] = (acc_nxt == '0);
      sr_nxt[F_S] = acc_nxt[DW-1];
    end
  end

  // Architectural registers: loader address, IR/DR latching, EXECUTE commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      acc       <= '0;
      sr        <= '0;
      ir        <= '0;
      dr        <= '0;
      load_addr <= '0;
    end else begin
      case (cur)
        S_LOAD: if (ld_acc) begin
          load_addr <= load_addr + AW'(1);
          if (load_done) pc <= '0;
        end
        S_FETCH:  ir <= pmem[pc];
        S_DECODE: dr <= dmem[dadr];
        S_EXEC: begin
          acc <= acc_nxt;
          sr  <= sr_nxt;
          pc  <= pc_nxt;
        end
        default: ;
      endcase
    end
  end

  // Program memory write port, fed only by the loader
  always_ff @(posedge clk) begin
    if (!rst && ld_acc) pmem[load_addr] <= ld_data;
  end

  // Data memory write port; the store lands before the next DECODE read
  always_ff @(posedge clk) begin
    if (!rst && cur == S_EXEC && op == OP_ST) dmem[dadr] <= acc;
  end

endmodule
